axi_stream_remove_header: RTL and testbench
===========================================

# axi_stream_remove_header

Strips a run-time-selected number of leading header bytes from each AXI-Stream packet. The remaining payload is re-aligned so it is MSB-first and gap-free. The stripped header bytes are reported on a side port, right-aligned. This block sits on the receive side and undoes what `axi_stream_insert_header` does on the transmit side. Byte order matches that block: byte lane DATA_BYTE_WD-1 (the MSB) is the first byte on the wire, and keep masks are contiguous from the MSB.

## Interface
- DATA_WD, 32, stream data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- LEN_WD, $clog2(DATA_BYTE_WD)+1, width of the strip-length field
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- valid_in / ready_in  in / out  1 / 1  upstream handshake
- data_in  in  DATA_WD  upstream data
- keep_in  in  DATA_BYTE_WD  upstream byte enables
- last_in  in  1  marks the final beat of a packet
- valid_out / ready_out  out / in  1 / 1  downstream handshake
- data_out  out  DATA_WD  payload; bytes outside keep_out are driven 0
- keep_out  out  DATA_BYTE_WD  payload byte enables
- last_out  out  1  marks the final payload beat
- valid_strip / ready_strip  in / out  1 / 1  per-packet strip request handshake
- strip_len  in  LEN_WD  header byte count H, legal range 0..DATA_BYTE_WD
- header_valid  out  1  one-cycle pulse; header fields valid in that cycle
- header_out  out  DATA_WD  stripped header bytes, right-aligned, upper bytes 0
- keep_header  out  DATA_BYTE_WD  low-contiguous mask of the header bytes actually present

## Operation
- Input rules:
  - Every non-last input beat has keep_in all ones.
  - The last beat carries K valid bytes (1..DATA_BYTE_WD), MSB-contiguous.
  - One strip request is consumed per packet.
- Storage: one DATA_WD buffer buf holding the previous input beat; registered output stage; registers H and K.
- States:
  - IDLE:
    - ready_strip=1, ready_in=0.
    - On strip handshake: latch H=strip_len, go to FIRST.
  - FIRST:
    - ready_in=1; the output stage is not loaded in this state.
    - On input handshake: buf<=data_in.
    - Pulse header_valid with header_out=data_in>>8*(DATA_BYTE_WD-H), keep_header=(1<<min(K_or_W,H))-1, with bytes above the mask zeroed.
    - If last_in and K<=H: no payload is emitted; go to IDLE.
    - If last_in and K>H: go to DRAIN.
    - Otherwise: go to STREAM.
  - STREAM:
    - ready_in = !valid_out || ready_out.
    - On input handshake: the output stage loads (buf<<8H) | (data_in>>8(DATA_BYTE_WD-H)); buf<=data_in.
    - For H=0, the shifted data_in term is 0. For H=DATA_BYTE_WD, the buf term is 0.
    - If !last_in: keep_out all ones, last_out=0.
    - If last_in and K<=H: byte count (DATA_BYTE_WD-H)+K, last_out=1, go to IDLE.
    - If last_in and K>H: keep_out all ones, last_out=0, go to DRAIN.
  - DRAIN:
    - ready_in=0.
    - When the output stage is free: load buf<<8H with K-H bytes and last_out=1, then go to IDLE.
- keep_out for n bytes = the n MSB-contiguous ones. data_out is masked by keep_out.
- A strip_len value greater than DATA_BYTE_WD is clamped to DATA_BYTE_WD.

## Timing
- Reset values:
  - valid_out=0, data_out=0, keep_out=0, last_out=0.
  - header_valid=0, header_out=0, keep_header=0.
  - State is IDLE, so ready_in=0 and ready_strip=1.
- ready_in and ready_strip are combinational from state and the output-stage status only. They do not depend on valid_in or valid_strip.
- Strip handshake at edge t: FIRST is entered at t+1, so the earliest data acceptance is at edge t+1.
- A valid_in asserted during IDLE is not accepted.
- header_valid is high exactly one cycle, the cycle after the first-beat handshake.
- Payload latency: a payload beat is on data_out in the cycle after the input beat that completes it is accepted.
- Throughput: one beat per cycle in STREAM while ready_out=1. DRAIN adds one cycle per packet when K>H.
- Output stall: while valid_out=1 and ready_out=0, data_out, keep_out and last_out are held stable and ready_in=0.
- Packet turnaround: IDLE can accept the next strip request while the final beat is still waiting in the output stage.
- Reset mid-packet: the block returns to IDLE immediately and partial output is discarded. valid_out drops asynchronously.

## Test plan
- H=3 (strip_len=3), input beats AABBCCDD, EEFF0011, 22334455 (last, keep 1100):
  - Header: header_out=00AABBCC, keep_header=0111.
  - Output: DDEEFF00/1111, then 11223300/1110 with last_out=1.
- H=1, input beats 01020304, 05060708 (last, keep 1111):
  - Header: header_out=00000001, keep_header=0001.
  - Output: 02030405/1111, then DRAIN emits 06070800/1110 with last_out=1.
- H=0, single beat 11223344 (last, keep 1100):
  - Header: keep_header=0000, header_out=0.
  - Output: 11220000/1100 with last_out=1.
- H=4, single beat 11223344 (last, keep 1111):
  - Header: header_out=11223344, keep_header=1111.
  - No valid_out at any point; ready_strip=1 on the following cycle.
- Case 1 with ready_out held 0 for 3 cycles after the first output beat:
  - The first output beat is held stable and ready_in=0 throughout the stall.
  - The full byte sequence is intact after release.
- rst_n asserted during STREAM:
  - valid_out=0 at once and the block is in IDLE.
  - The next packet (case 1 stimulus) produces exactly case 1 outputs.

Source files
------------

// File: rtl/axi_stream_remove_header_if.sv
// rtl/axi_stream_remove_header_if.sv - handshake bundle for the header stripper
//
// Groups the upstream stream, downstream stream, strip-request and header
// side-port signals.
//   slave  : view of the stripper (consumes input/strip, produces output/header)
//   master : view of the environment driving/consuming the stripper
interface axi_stream_remove_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;

  logic                    valid_strip;
  logic                    ready_strip;
  logic [LEN_WD-1:0]       strip_len;

  logic                    header_valid;
  logic [DATA_WD-1:0]      header_out;
  logic [DATA_BYTE_WD-1:0] keep_header;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    input  valid_strip, strip_len,
    output ready_strip,
    output header_valid, header_out, keep_header
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    output valid_strip, strip_len,
    input  ready_strip,
    input  header_valid, header_out, keep_header
  );
endinterface

// File: rtl/axi_stream_remove_header.sv
// rtl/axi_stream_remove_header.sv - strips H leading header bytes from each stream packet
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of axi_stream_remove_header_if
//           valid_in/ready_in/data_in/keep_in/last_in      upstream beats
//           valid_out/ready_out/data_out/keep_out/last_out re-aligned payload
//           valid_strip/ready_strip/strip_len              per-packet header length H
//           header_valid/header_out/keep_header            stripped header, right-aligned
// Byte lane DATA_BYTE_WD-1 is the first byte on the wire; keep masks are
// MSB-contiguous on the streams and LSB-contiguous on keep_header.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input logic                       clk,
  input logic                       rst_n,
  axi_stream_remove_header_if.slave bus
);

  localparam logic [LEN_WD-1:0] W_LEN = LEN_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, DRAIN} state_t;

  state_t                  state;
  logic [LEN_WD-1:0]       h_q;
  logic [LEN_WD-1:0]       k_q;
  logic [DATA_WD-1:0]      buf_q;

  logic                    valid_out_q;
  logic [DATA_WD-1:0]      data_out_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q;
  logic                    last_out_q;
  logic                    header_valid_q;
  logic [DATA_WD-1:0]      header_out_q;
  logic [DATA_BYTE_WD-1:0] keep_header_q;

  // n ones starting at the MSB lane
  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [LEN_WD-1:0] n);
    msb_mask = ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  // n ones starting at lane 0
  function automatic logic [DATA_BYTE_WD-1:0] lsb_mask(input logic [LEN_WD-1:0] n);
    lsb_mask = ~({DATA_BYTE_WD{1'b1}} << n);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] m);
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      byte_mask[8*i +: 8] = {8{m[i]}};
    end
  endfunction

  function automatic logic [LEN_WD-1:0] count_keep(input logic [DATA_BYTE_WD-1:0] keep);
    count_keep = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      count_keep = count_keep + LEN_WD'(keep[i]);
    end
  endfunction

  logic                    out_free;
  logic                    ready_in_c;
  logic                    in_hs;
  logic [LEN_WD-1:0]       kin;
  logic [LEN_WD-1:0]       hdr_len;
  logic [LEN_WD-1:0]       w_minus_h;
  logic [LEN_WD-1:0]       strip_clamped;
  logic [LEN_WD+2:0]       sh_buf;
  logic [LEN_WD+2:0]       sh_in;
  logic [DATA_WD-1:0]      buf_shift;
  logic [DATA_WD-1:0]      in_shift;

  logic                    load_en;
  logic [DATA_WD-1:0]      load_word;
  logic [LEN_WD-1:0]       load_len;
  logic                    load_last;

  // Handshake readies depend only on state and output-stage occupancy.
  assign out_free   = !valid_out_q || bus.ready_out;
  assign ready_in_c = (state == FIRST) || ((state == STREAM) && out_free);
  assign in_hs      = bus.valid_in && ready_in_c;

  assign kin           = bus.last_in ? count_keep(bus.keep_in) : W_LEN;
  assign hdr_len       = (kin < h_q) ? kin : h_q;
  assign w_minus_h     = W_LEN - h_q;
  assign strip_clamped = (bus.strip_len > W_LEN) ? W_LEN : bus.strip_len;

  // Shifts of a full word width yield zero, which covers H=0 and H=DATA_BYTE_WD.
  assign sh_buf    = {h_q, 3'b000};
  assign sh_in     = {w_minus_h, 3'b000};
  assign buf_shift = buf_q << sh_buf;
  assign in_shift  = bus.data_in >> sh_in;

  always_comb begin
    load_en   = 1'b0;
    load_word = buf_shift | in_shift;
    load_len  = W_LEN;
    load_last = 1'b0;
    if ((state == STREAM) && in_hs) begin
      load_en = 1'b1;
      // Last beat fits entirely in this output word: its tail is the final beat.
      if (bus.last_in && (kin <= h_q)) begin
        load_len  = w_minus_h + kin;
        load_last = 1'b1;
      end
    end else if ((state == DRAIN) && out_free) begin
      load_en   = 1'b1;
      load_word = buf_shift;
      load_len  = k_q - h_q;
      load_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      h_q            <= '0;
      k_q            <= '0;
      buf_q          <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      header_valid_q <= 1'b0;
      header_out_q   <= '0;
      keep_header_q  <= '0;
    end else begin
      header_valid_q <= 1'b0;

      if (load_en) begin
        valid_out_q <= 1'b1;
        data_out_q  <= load_word & byte_mask(msb_mask(load_len));
        keep_out_q  <= msb_mask(load_len);
        last_out_q  <= load_last;
      end else if (bus.ready_out) begin
        valid_out_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.valid_strip) begin
            h_q   <= strip_clamped;
            state <= FIRST;
          end
        end
        FIRST: begin
          if (in_hs) begin
            buf_q          <= bus.data_in;
            header_valid_q <= 1'b1;
            header_out_q   <= in_shift & byte_mask(lsb_mask(hdr_len));
            keep_header_q  <= lsb_mask(hdr_len);
            k_q            <= kin;
            if (!bus.last_in) begin
              state <= STREAM;
            end else if (kin <= h_q) begin
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end
        end
        STREAM: begin
          if (in_hs) begin
            buf_q <= bus.data_in;
            k_q   <= kin;
            if (bus.last_in) begin
              state <= (kin <= h_q) ? IDLE : DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_free) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_in     = ready_in_c;
  assign bus.ready_strip  = (state == IDLE);
  assign bus.valid_out    = valid_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.keep_out     = keep_out_q;
  assign bus.last_out     = last_out_q;
  assign bus.header_valid = header_valid_q;
  assign bus.header_out   = header_out_q;
  assign bus.keep_header  = keep_header_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb/tb_axi_stream_remove_header.sv - scoreboard bench for axi_stream_remove_header
module tb_axi_stream_remove_header;
  localparam int DATA_WD = 32;
  localparam int W       = 4;
  localparam int LEN_WD  = 3;
  localparam int LIMIT   = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_remove_header_if #(.DATA_WD(DATA_WD)) bus ();

  axi_stream_remove_header #(.DATA_WD(DATA_WD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } hdr_t;

  beat_t       exp_q[$];
  hdr_t        hdr_q[$];
  logic [31:0] pkt_data[$];
  int          pkt_k;

  int errors = 0;
  int checks = 0;

  logic sb_on = 1'b0;
  int   rdy_mode = 0;
  logic rdy_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [7:0] wire_byte(input logic [31:0] word, input int j);
    return word[8*(W-1-j) +: 8];
  endfunction

  function automatic logic [3:0] first_n_lanes(input int n);
    logic [3:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[W-1-j] = 1'b1;
    return m;
  endfunction

  // Reference: flatten the packet to a byte list, drop H bytes, re-chunk.
  task automatic push_model(input int h_raw);
    int          h, n, first_len, hl, cnt;
    logic [7:0]  bytes[$];
    beat_t       e;
    hdr_t        hd;
    h = (h_raw > W) ? W : h_raw;
    n = pkt_data.size();
    for (int b = 0; b < n; b++)
      for (int j = 0; j < W; j++)
        if (b < n - 1 || j < pkt_k) bytes.push_back(wire_byte(pkt_data[b], j));
    first_len = (n == 1) ? pkt_k : W;
    hl = (h < first_len) ? h : first_len;
    hd.d = '0;
    hd.k = '0;
    for (int i = 0; i < hl; i++) begin
      hd.d[8*i +: 8] = wire_byte(pkt_data[0], h - 1 - i);
      hd.k[i] = 1'b1;
    end
    hdr_q.push_back(hd);
    for (int p = h; p < bytes.size(); p += W) begin
      cnt = bytes.size() - p;
      if (cnt > W) cnt = W;
      e.data = '0;
      for (int j = 0; j < cnt; j++) e.data[8*(W-1-j) +: 8] = bytes[p+j];
      e.keep = first_n_lanes(cnt);
      e.last = (p + W >= bytes.size());
      exp_q.push_back(e);
    end
  endtask

  // ready_out driver (sole writer of ready_out)
  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.ready_out = ($urandom_range(0, 3) != 0);
      else bus.ready_out = rdy_force;
    end
  end

  // Monitor / scoreboard
  logic        stall_q = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    if (!rst_n || !sb_on) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("stall_hold", {27'd0, bus.valid_out, bus.last_out, bus.keep_out, bus.data_out},
              {27'd0, 1'b1, held});
      if (bus.valid_out) begin
        if (bus.ready_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected none", bus.data_out);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("payload_beat", {27'd0, bus.last_out, bus.keep_out, bus.data_out},
                  {27'd0, e.last, e.keep, e.data});
          end
          stall_q = 1'b0;
        end else begin
          stall_q = 1'b1;
          held = {bus.last_out, bus.keep_out, bus.data_out};
        end
      end else begin
        stall_q = 1'b0;
      end
      if (bus.header_valid) begin
        if (hdr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_header: got %h expected none", bus.header_out);
        end else begin
          hdr_t hd;
          hd = hdr_q.pop_front();
          check("header", {28'd0, bus.keep_header, bus.header_out}, {28'd0, hd.k, hd.d});
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_strip(input int h);
    logic hs;
    bus.valid_strip = 1'b1;
    bus.strip_len = LEN_WD'(h);
    for (int c = 0; ; c++) begin
      @(negedge clk);
      hs = bus.ready_strip;
      @(posedge clk);
      if (hs) break;
      if (c > LIMIT) begin
        timeout_fail("strip_handshake");
        break;
      end
    end
    #1;
    bus.valid_strip = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic hs;
    bus.valid_in = 1'b1;
    bus.data_in = d;
    bus.keep_in = k;
    bus.last_in = l;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      hs = bus.ready_in;
      @(posedge clk);
      if (hs) break;
      if (c > LIMIT) begin
        timeout_fail("beat_handshake");
        break;
      end
    end
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic run_packet(input int h, input int max_gap, input logic model);
    int n;
    n = pkt_data.size();
    if (model) push_model(h);
    send_strip(h);
    gap($urandom_range(0, max_gap));
    for (int b = 0; b < n; b++) begin
      send_beat(pkt_data[b], (b == n - 1) ? first_n_lanes(pkt_k) : 4'hF, b == n - 1);
      gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic load_case1();
    pkt_data = {32'hAABBCCDD, 32'hEEFF0011, 32'h22334455};
    pkt_k = 2;
  endtask

  task automatic wait_drained();
    for (int c = 0; c < LIMIT && (exp_q.size() != 0 || hdr_q.size() != 0); c++) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.keep_in = '0;
    bus.last_in = 1'b0;
    bus.valid_strip = 1'b0;
    bus.strip_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_keep_out", bus.keep_out, 0);
    check("rst_last_out", bus.last_out, 0);
    check("rst_header_valid", bus.header_valid, 0);
    check("rst_header_out", bus.header_out, 0);
    check("rst_keep_header", bus.keep_header, 0);
    check("rst_ready_in", bus.ready_in, 0);
    check("rst_ready_strip", bus.ready_strip, 1);
    sb_on = 1'b1;

    // valid_in during IDLE is ignored
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    bus.data_in = 32'hDEADBEEF;
    bus.keep_in = 4'hF;
    bus.last_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_in", bus.ready_in, 0);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;

    // Directed cases
    load_case1();
    run_packet(3, 0, 1'b1);
    pkt_data = {32'h01020304, 32'h05060708};
    pkt_k = 4;
    run_packet(1, 0, 1'b1);
    pkt_data = {32'h11223344};
    pkt_k = 2;
    run_packet(0, 0, 1'b1);
    pkt_data = {32'h11223344};
    pkt_k = 4;
    run_packet(4, 0, 1'b1);
    check("h4_ready_strip", bus.ready_strip, 1);
    wait_drained();

    // Case 1 with a three-cycle output stall after the first payload beat
    rdy_force = 1'b0;
    gap(2);
    load_case1();
    fork
      run_packet(3, 0, 1'b1);
      begin
        int c;
        c = 0;
        @(negedge clk);
        while (!bus.valid_out && c < LIMIT) begin
          @(negedge clk);
          c++;
        end
        if (c >= LIMIT) timeout_fail("stall_wait_valid");
        for (int i = 0; i < 3; i++) begin
          check("stall_ready_in", bus.ready_in, 0);
          @(negedge clk);
        end
        rdy_force = 1'b1;
      end
    join
    wait_drained();

    // Reset in the middle of STREAM
    sb_on = 1'b0;
    load_case1();
    send_strip(3);
    send_beat(pkt_data[0], 4'hF, 1'b0);
    send_beat(pkt_data[1], 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", bus.valid_out, 0);
    check("midrst_ready_strip", bus.ready_strip, 1);
    check("midrst_ready_in", bus.ready_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    hdr_q.delete();
    sb_on = 1'b1;
    gap(1);
    run_packet(3, 0, 1'b1);
    wait_drained();

    // Randomized packets with random backpressure and gaps
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(1, 4);
      pkt_data.delete();
      for (int b = 0; b < n; b++) pkt_data.push_back($urandom);
      pkt_k = $urandom_range(1, 4);
      run_packet($urandom_range(0, 7), 2, 1'b1);
    end
    rdy_mode = 0;
    rdy_force = 1'b1;
    wait_drained();
    check("drain_payload_queue", exp_q.size(), 0);
    check("drain_header_queue", hdr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
